// File: rtl/lcd_bus_sequencer.sv
// ---------------------------------------------------------------------------
// lcd_bus_sequencer
//
// Purpose:
//   Write-only driver for a KS0066/HD44780-compatible 16x2 character LCD on
//   its 8-bit parallel bus. After reset it waits PowerUpTime cycles, sends
//   the four-instruction init sequence (0x38, 0x0C, 0x01, 0x06), then
//   repeatedly redraws both lines from LineA/LineB. Each frame is:
//   0x80, 16 characters of LineA, 0xC0, 16 characters of LineB, followed by
//   RefreshTime idle cycles. The LCD busy flag is never read; all pacing
//   comes from fixed cycle-count waits.
//
//   Every bus transfer is SETUP (1 cycle, E=0) -> PULSE (EPulse cycles,
//   E=1) -> HOLD (wait cycles, E=0). DB and RS are loaded only on entry to
//   SETUP, so they are stable for the whole strobe and hold.
//
// Configuration macro:
//   LCD_LINE_SNAPSHOT_EN - when defined, LineA/LineB are copied into an
//   internal 256-bit snapshot on the cycle the FSM enters FRAME, so every
//   frame shows one coherent image. When undefined, each character is
//   sampled live at the edge that starts its SETUP cycle.
//
// Ports:
//   mclk        in   main clock
//   rst         in   synchronous active-high reset
//   LineA[127:0] in  top line, byte [7:0] = leftmost column
//   LineB[127:0] in  bottom line, same packing
//   DB[7:0]     out  LCD data bus
//   RS          out  register select (0 = instruction, 1 = data)
//   E           out  LCD enable strobe
//   RW          out  read/write select, constant 0
//   ready       out  high once initialisation is complete
//   frame_done  out  one-cycle pulse in the first REFRESH cycle
// ---------------------------------------------------------------------------
module lcd_bus_sequencer #(
  parameter int unsigned EPulse        = 2,
  parameter logic [15:0] InsWaitTime   = 16'd10,
  parameter int unsigned DataWaitTime  = 10,
  parameter int unsigned ClearWaitTime = 200,
  parameter int unsigned PowerUpTime   = 1000,
  parameter int unsigned RefreshTime   = 320
) (
  input  logic         mclk,
  input  logic         rst,
  input  logic [127:0] LineA,
  input  logic [127:0] LineB,
  output logic [7:0]   DB,
  output logic         RS,
  output logic         E,
  output logic         RW,
  output logic         ready,
  output logic         frame_done
);

  localparam logic [31:0] E_PULSE    = 32'(EPulse);
  localparam logic [31:0] INS_WAIT   = 32'(InsWaitTime);
  localparam logic [31:0] DATA_WAIT  = 32'(DataWaitTime);
  localparam logic [31:0] CLEAR_WAIT = 32'(ClearWaitTime);
  localparam logic [31:0] POWERUP    = 32'(PowerUpTime);
  localparam logic [31:0] REFRESH    = 32'(RefreshTime);

  localparam logic [7:0] CMD_LINE_A = 8'h80;
  localparam logic [7:0] CMD_LINE_B = 8'hC0;

  typedef enum logic [1:0] {
    ST_POWERUP,
    ST_INIT,
    ST_FRAME,
    ST_REFRESH
  } state_e;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_PULSE,
    PH_HOLD
  } phase_e;

  // Init instruction table, indexed by init step.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
      2'd1:    cmd = 8'h0C;  // display on, cursor off
      2'd2:    cmd = 8'h01;  // clear display (long wait)
      default: cmd = 8'h06;  // increment, no shift
    endcase
    return cmd;
  endfunction

  // Pick one character byte from the selected line.
  function automatic logic [7:0] pick_char(input logic [127:0] line_a,
                                           input logic [127:0] line_b,
                                           input logic         sel_b,
                                           input logic [3:0]   idx);
    logic [127:0] line;
    line = sel_b ? line_b : line_a;
    return line[{idx, 3'b000} +: 8];
  endfunction

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  init_idx_q, init_idx_d;
  logic        line_sel_q, line_sel_d;   // 0 = LineA, 1 = LineB
  logic        is_addr_q, is_addr_d;     // current transfer is 0x80/0xC0
  logic [3:0]  char_idx_q, char_idx_d;
  logic [7:0]  db_q, db_d;
  logic        rs_q, rs_d;
  logic        e_q, e_d;
  logic        ready_q, ready_d;
  logic        frame_done_q, frame_done_d;

  logic        enter_frame;
  logic        xfer_done;
  logic [31:0] cur_wait;
  logic [127:0] src_a, src_b;

`ifdef LCD_LINE_SNAPSHOT_EN
  logic [255:0] snap_q;

  // NOTE: the snapshot is pure data storage that is always overwritten before
  // it is read (on FRAME entry), so it carries no reset.
  always_ff @(posedge mclk) begin
    if (enter_frame) begin
      snap_q <= {LineB, LineA};
    end
  end

  assign src_a = snap_q[127:0];
  assign src_b = snap_q[255:128];
`else
  assign src_a = LineA;
  assign src_b = LineB;
`endif

  // Hold length of the transfer currently on the bus.
  always_comb begin
    if (state_q == ST_INIT) begin
      cur_wait = (init_idx_q == 2'd2) ? CLEAR_WAIT : INS_WAIT;
    end else begin
      cur_wait = is_addr_q ? INS_WAIT : DATA_WAIT;
    end
  end

  // NOTE: every variable assigned here gets a default first; a path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    init_idx_d   = init_idx_q;
    line_sel_d   = line_sel_q;
    is_addr_d    = is_addr_q;
    char_idx_d   = char_idx_q;
    db_d         = db_q;
    rs_d         = rs_q;
    e_d          = e_q;
    ready_d      = ready_q;
    frame_done_d = 1'b0;
    enter_frame  = 1'b0;
    xfer_done    = 1'b0;

    case (state_q)
      ST_POWERUP: begin
        if (cnt_q + 32'd1 >= POWERUP) begin
          state_d    = ST_INIT;
          phase_d    = PH_SETUP;
          cnt_d      = '0;
          init_idx_d = 2'd0;
          db_d       = init_cmd(2'd0);
          rs_d       = 1'b0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_INIT, ST_FRAME: begin
        case (phase_q)
          PH_SETUP: begin
            phase_d = PH_PULSE;
            e_d     = 1'b1;
            cnt_d   = '0;
          end
          PH_PULSE: begin
            if (cnt_q + 32'd1 >= E_PULSE) begin
              e_d   = 1'b0;
              cnt_d = '0;
              // A zero wait skips HOLD; next SETUP follows PULSE directly.
              if (cur_wait == 32'd0) begin
                xfer_done = 1'b1;
              end else begin
                phase_d = PH_HOLD;
              end
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
          default: begin  // PH_HOLD
            if (cnt_q + 32'd1 >= cur_wait) begin
              xfer_done = 1'b1;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
        endcase

        if (xfer_done) begin
          cnt_d   = '0;
          phase_d = PH_SETUP;
          if (state_q == ST_INIT) begin
            if (init_idx_q == 2'd3) begin
              ready_d     = 1'b1;
              enter_frame = 1'b1;
            end else begin
              init_idx_d = init_idx_q + 2'd1;
              db_d       = init_cmd(init_idx_q + 2'd1);
              rs_d       = 1'b0;
            end
          end else if (is_addr_q) begin
            // Address set just finished: first character of this line.
            is_addr_d = 1'b0;
            rs_d      = 1'b1;
            db_d      = pick_char(src_a, src_b, line_sel_q, char_idx_q);
          end else if (char_idx_q == 4'd15) begin
            // Index wraps back to 0 for the next line or frame.
            char_idx_d = char_idx_q + 4'd1;
            if (!line_sel_q) begin
              line_sel_d = 1'b1;
              is_addr_d  = 1'b1;
              rs_d       = 1'b0;
              db_d       = CMD_LINE_B;
            end else begin
              state_d      = ST_REFRESH;
              frame_done_d = 1'b1;
            end
          end else begin
            char_idx_d = char_idx_q + 4'd1;
            rs_d       = 1'b1;
            db_d       = pick_char(src_a, src_b, line_sel_q, char_idx_q + 4'd1);
          end
        end
      end

      default: begin  // ST_REFRESH
        if (cnt_q + 32'd1 >= REFRESH) begin
          enter_frame = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
    endcase

    // Common entry into FRAME, from INIT or REFRESH: start with 0x80.
    if (enter_frame) begin
      state_d    = ST_FRAME;
      phase_d    = PH_SETUP;
      cnt_d      = '0;
      line_sel_d = 1'b0;
      is_addr_d  = 1'b1;
      char_idx_d = 4'd0;
      db_d       = CMD_LINE_A;
      rs_d       = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q      <= ST_POWERUP;
      phase_q      <= PH_SETUP;
      cnt_q        <= '0;
      init_idx_q   <= 2'd0;
      line_sel_q   <= 1'b0;
      is_addr_q    <= 1'b0;
      char_idx_q   <= 4'd0;
      db_q         <= 8'h00;
      rs_q         <= 1'b0;
      e_q          <= 1'b0;
      ready_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      init_idx_q   <= init_idx_d;
      line_sel_q   <= line_sel_d;
      is_addr_q    <= is_addr_d;
      char_idx_q   <= char_idx_d;
      db_q         <= db_d;
      rs_q         <= rs_d;
      e_q          <= e_d;
      ready_q      <= ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign DB         = db_q;
  assign RS         = rs_q;
  assign E          = e_q;
  assign RW         = 1'b0;
  assign ready      = ready_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lcd_bus_sequencer
//
// Directed bench for lcd_bus_sequencer with EPulse=1, InsWaitTime=4,
// DataWaitTime=2, ClearWaitTime=8, PowerUpTime=10, RefreshTime=20.
// Cycle N is the N-th clock period after the last edge that sampled rst
// high; outputs are sampled on the falling edge inside that period.
// A table of {cycle, expected outputs} covers init and the first frame;
// hand-written sequences cover the mid-frame input change, three-frame
// continuity and reset during a pulse.
// ---------------------------------------------------------------------------
module tb_lcd_bus_sequencer;

  logic         clk;
  logic         rst;
  logic [127:0] line_a;
  logic [127:0] line_b;
  logic [7:0]   db;
  logic         rs;
  logic         e;
  logic         rw;
  logic         ready;
  logic         frame_done;

  lcd_bus_sequencer #(
    .EPulse       (1),
    .InsWaitTime  (16'd4),
    .DataWaitTime (2),
    .ClearWaitTime(8),
    .PowerUpTime  (10),
    .RefreshTime  (20)
  ) dut (
    .mclk      (clk),
    .rst       (rst),
    .LineA     (line_a),
    .LineB     (line_b),
    .DB        (db),
    .RS        (rs),
    .E         (e),
    .RW        (rw),
    .ready     (ready),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc  = 0;
  int base = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the falling edge inside relative cycle n.
  task automatic wait_to(input int n);
    if (cyc - base > n) begin
      total++;
      bad++;
      $display("FAIL order: at cycle %0d expected to reach %0d", cyc - base, n);
    end
    while (cyc - base < n) @(negedge clk);
  endtask

  // Bus monitor: RW stuck low, DB stable while E is high, frame_done log.
  int   rw_viol  = 0;
  int   bus_viol = 0;
  int   fd_cycles[$];
  logic prev_e   = 1'b0;
  logic [7:0] prev_db = 8'h00;
  always @(negedge clk) begin
    if (rw !== 1'b0) rw_viol++;
    if (e === 1'b1 && prev_e === 1'b1 && db !== prev_db) bus_viol++;
    if (frame_done === 1'b1) fd_cycles.push_back(cyc - base);
    prev_e  = e;
    prev_db = db;
  end

  typedef struct {
    int         cyc;
    logic       e;
    logic [7:0] db;
    logic       rs;
    logic       rdy;
    logic       fd;
  } vec_t;

  function automatic vec_t mk(input int c, input logic ev, input logic [7:0] d,
                              input logic r, input logic rd, input logic f);
    vec_t v;
    v.cyc = c; v.e = ev; v.db = d; v.rs = r; v.rdy = rd; v.fd = f;
    return v;
  endfunction

  vec_t vecs[$];

  task automatic run_vecs(input int max_cyc);
    foreach (vecs[i]) begin
      if (vecs[i].cyc <= max_cyc) begin
        wait_to(vecs[i].cyc);
        check($sformatf("vec@%0d {E,DB,RS,ready,fd}", vecs[i].cyc),
              {20'd0, e, db, rs, ready, frame_done},
              {20'd0, vecs[i].e, vecs[i].db, vecs[i].rs, vecs[i].rdy, vecs[i].fd});
      end
    end
  endtask

  initial begin
    // Init sequence
    vecs.push_back(mk(0,   0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(9,   0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(10,  0, 8'h38, 0, 0, 0));
    vecs.push_back(mk(11,  1, 8'h38, 0, 0, 0));
    vecs.push_back(mk(12,  0, 8'h38, 0, 0, 0));
    vecs.push_back(mk(17,  1, 8'h0C, 0, 0, 0));
    vecs.push_back(mk(23,  1, 8'h01, 0, 0, 0));
    vecs.push_back(mk(31,  0, 8'h01, 0, 0, 0));
    vecs.push_back(mk(32,  0, 8'h06, 0, 0, 0));
    vecs.push_back(mk(33,  1, 8'h06, 0, 0, 0));
    vecs.push_back(mk(37,  0, 8'h06, 0, 0, 0));
    vecs.push_back(mk(38,  0, 8'h80, 0, 1, 0));
    // First frame
    vecs.push_back(mk(39,  1, 8'h80, 0, 1, 0));
    vecs.push_back(mk(45,  1, 8'h4D, 1, 1, 0));
    vecs.push_back(mk(46,  0, 8'h4D, 1, 1, 0));
    vecs.push_back(mk(49,  1, 8'h6F, 1, 1, 0));
    vecs.push_back(mk(53,  1, 8'h6E, 1, 1, 0));
    vecs.push_back(mk(57,  1, 8'h20, 1, 1, 0));
    vecs.push_back(mk(105, 1, 8'h20, 1, 1, 0));
    vecs.push_back(mk(109, 1, 8'hC0, 0, 1, 0));
    vecs.push_back(mk(115, 1, 8'h41, 1, 1, 0));
    vecs.push_back(mk(175, 1, 8'h41, 1, 1, 0));
    vecs.push_back(mk(177, 0, 8'h41, 1, 1, 0));
    vecs.push_back(mk(178, 0, 8'h41, 1, 1, 1));
    vecs.push_back(mk(179, 0, 8'h41, 1, 1, 0));
    vecs.push_back(mk(198, 0, 8'h80, 0, 1, 0));
    vecs.push_back(mk(199, 1, 8'h80, 0, 1, 0));

    line_a = {{13{8'h20}}, 8'h6E, 8'h6F, 8'h4D};
    line_b = {16{8'h41}};

    // Reset held for three edges
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset outputs {E,DB,RS,RW,ready,fd}",
          {19'd0, e, db, rs, rw, ready, frame_done}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    base = cyc;

    run_vecs(1000);

    // Mid-frame change during the 5th character of frame 2
    wait_to(205);
    check("frame2 col0 before change", {24'd0, db}, 32'h4D);
    wait_to(221);
    check("frame2 col4 strobe", {23'd0, e, db}, {23'd0, 1'b1, 8'h20});
    line_a[7:0]     = 8'h54;
    line_a[127:120] = 8'h21;
    wait_to(265);
`ifdef LCD_LINE_SNAPSHOT_EN
    check("frame2 col15 (snapshot)", {23'd0, e, db}, {23'd0, 1'b1, 8'h20});
`else
    check("frame2 col15 (live)", {23'd0, e, db}, {23'd0, 1'b1, 8'h21});
`endif
    wait_to(365);
    check("frame3 col0 new value", {23'd0, e, db}, {23'd0, 1'b1, 8'h54});
    wait_to(425);
    check("frame3 col15 new value", {23'd0, e, db}, {23'd0, 1'b1, 8'h21});

    // Three frames: pulse count and spacing
    wait_to(500);
    check("frame_done count", fd_cycles.size(), 3);
    if (fd_cycles.size() == 3) begin
      check("frame_done first", fd_cycles[0], 178);
      check("frame_done spacing 1-2", fd_cycles[1] - fd_cycles[0], 180 - 20);
      check("frame_done spacing 2-3", fd_cycles[2] - fd_cycles[1], 180 - 20);
    end

    // Reset while E is high (0x80 strobe of frame 4)
    wait_to(519);
    check("frame4 0x80 strobe", {23'd0, e, db}, {23'd0, 1'b1, 8'h80});
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset mid-pulse E", {31'd0, e}, 32'd0);
    check("reset mid-pulse ready", {31'd0, ready}, 32'd0);
    check("reset mid-pulse DB", {24'd0, db}, 32'd0);
    rst = 1'b0;
    base = cyc;
    fd_cycles.delete();
    run_vecs(38);
    check("no frame_done during re-init", fd_cycles.size(), 0);

    check("RW stuck low", rw_viol, 0);
    check("DB stable while E high", bus_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
